regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised register file with N read ports, one write port, same-cycle write-to-read
//  bypass and a per-register busy scoreboard with stall generation.
//  Successor to the single-port register_file. Serves as the architectural register store
//  for the pipelined core: decode issues destinations, writeback retires them, and
//  hazards stall issue.
// PARAMETERS
//  XLEN    32  data width in bits
//  NREG    32  number of registers; must be a power of two; register 0 is hardwired zero
//  NRD     2   number of read ports (1..4)
//  BYPASS  1   1 = a same-cycle write is forwarded to reads; 0 = reads see only stored values
//  AW      $clog2(NREG) (localparam)  register address width
// PORTS
//  clk      in   1         rising-edge clock
//  rst      in   1         asynchronous reset, active-low
//  wr_en    in   1         writeback valid
//  wr_addr  in   AW        writeback destination
//  wr_data  in   XLEN      writeback data
//  rd_addr  in   NRD*AW    packed read addresses; port p occupies [p*AW +: AW]
//  rd_use   in   NRD       port p source is needed by the issuing instruction
//  rd_data  out  NRD*XLEN  packed read data, combinational
//  iss_en   in   1         issue request: mark iss_rd as busy
//  iss_rd   in   AW        destination of the issuing instruction
//  stall    out  1         hazard present; the issue is not accepted this cycle
//  busy     out  NREG      scoreboard bitmap; bit r = 1 means register r has a write pending
// BEHAVIOUR
//  - Reset (rst=0, async): all registers cleared to 0 and busy cleared to 0 immediately,
//    mid-cycle included. After reset: rd_data = 0 and stall = 0.
//  - Register 0: writes ignored; reads return 0; busy[0] is always 0; an issue to r0 sets nothing.
//  - Write: at posedge, if wr_en && wr_addr != 0, then reg[wr_addr] <= wr_data.
//    The value is visible from the array one cycle later.
//  - Read: combinational. rd_data[p] = reg[rd_addr[p]].
//    If BYPASS && wr_en && wr_addr == rd_addr[p] && wr_addr != 0, rd_data[p] = wr_data instead.
//  - Fwd(r) = BYPASS && wr_en && wr_addr == r.
//  - RAW hazard on port p: rd_use[p] && busy[rd_addr[p]] && !Fwd(rd_addr[p]).
//  - WAW hazard: iss_en && busy[iss_rd] && !(wr_en && wr_addr == iss_rd).
//  - stall = iss_en && (any RAW hazard on ports 0..NRD-1, or WAW hazard). Combinational.
//    stall is 0 whenever iss_en = 0.
//  - Issue accepted = iss_en && !stall && iss_rd != 0. On acceptance, busy[iss_rd] <= 1 at posedge.
//  - Writeback: at posedge, wr_en && wr_addr != 0 clears busy[wr_addr], unless an issue to the
//    same register is accepted in the same cycle. In that case issue wins and busy stays 1.
//  - A write to a non-busy register is legal; it updates data and leaves busy at 0.
//  - Issue and writeback to different registers in the same cycle: both take effect.
//  - With BYPASS=0, a busy source stalls until the cycle after its writeback.
// TESTING
//  1. Reset: hold rst=0, then release.
//     -> all rd_data = 0, busy = 0, stall = 0.
//     Write x5=0xDEADBEEF, then assert rst=0 mid-cycle -> busy and the x5 read drop to 0 at once.
//  2. Bypass: wr_en=1, wr_addr=3, wr_data=0x1234, rd_addr[0]=3 in the same cycle
//     -> rd_data[0] = 0x1234 (BYPASS=1).
//     With BYPASS=0 -> old value; 0x1234 appears the next cycle.
//  3. x0: write x0=0xFFFFFFFF and issue with iss_rd=0
//     -> reads of x0 return 0, busy[0] = 0, stall = 0.
//  4. RAW: issue iss_rd=7; next cycle issue with rd_addr[1]=7, rd_use[1]=1 -> stall = 1.
//     Same cycle with wr_en, wr_addr=7 -> stall = 0, forwarded data, busy[7] clears.
//     With rd_use[1]=0 -> no stall.
//  5. WAW/simultaneous: busy[9]=1; issue iss_rd=9 together with wr_en, wr_addr=9
//     -> stall = 0 and busy[9] remains 1.
//     Issue iss_rd=9 without the write -> stall = 1 and busy unchanged.
//  6. Sweep with NRD=4, NREG=16, XLEN=64: random issue/write streams checked against a
//     reference model; busy bitmap and rd_data match every cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Architectural register store for the pipelined core: NREG x XLEN register
//   file with NRD combinational read ports, one write (writeback) port,
//   optional same-cycle write-to-read forwarding, and a per-register busy
//   scoreboard that raises stall on RAW/WAW hazards at issue.
//   Register 0 is hardwired to zero and is never marked busy.
//
// Ports
//   clk      in   1         rising-edge clock
//   rst      in   1         asynchronous reset, active-low
//   wr_en    in   1         writeback valid
//   wr_addr  in   AW        writeback destination
//   wr_data  in   XLEN      writeback data
//   rd_addr  in   NRD*AW    packed read addresses, port p at [p*AW +: AW]
//   rd_use   in   NRD       port p source is needed by the issuing instruction
//   rd_data  out  NRD*XLEN  packed read data (combinational)
//   iss_en   in   1         issue request; marks iss_rd busy when accepted
//   iss_rd   in   AW        destination of the issuing instruction
//   stall    out  1         hazard present; issue not accepted this cycle
//   busy     out  NREG      scoreboard bitmap, bit r = write pending on r
module regfile_scoreboard #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_use,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                stall,
  output logic [NREG-1:0]     busy
);

  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic [NRD-1:0]  fwd_hit;
  logic [NRD-1:0]  raw;
  logic            waw;
  logic            accept;

  // Forwarding match per read port. Address 0 is excluded from the data path
  // below; for the hazard term it is harmless because busy[0] is never set.
  always_comb begin
    fwd_hit = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      fwd_hit[p] = BYP && wr_en && (wr_addr == rd_addr[p*AW +: AW]);
    end
  end

  always_comb begin
    rd_data = '0;
    raw     = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (rd_addr[p*AW +: AW] != '0) begin
        if (fwd_hit[p]) begin
          rd_data[p*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[p*XLEN +: XLEN] = regs_q[rd_addr[p*AW +: AW]];
        end
      end
      raw[p] = rd_use[p] && busy_q[rd_addr[p*AW +: AW]] && !fwd_hit[p];
    end
  end

  // A pending write to iss_rd that retires this cycle clears the WAW hazard
  // regardless of BYPASS: the scoreboard slot is free again at the edge.
  always_comb begin
    waw    = busy_q[iss_rd] && !(wr_en && (wr_addr == iss_rd));
    stall  = iss_en && ((|raw) || waw);
    accept = iss_en && !stall && (iss_rd != '0);
  end

  // Writeback clears first, then an accepted issue sets, so issue wins when
  // both target the same register in one cycle.
  always_comb begin
    busy_d = busy_q;
    if (wr_en && (wr_addr != '0)) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (accept) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) begin
        regs_q[wr_addr] <= wr_data;
      end
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule
